// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction fetch port (I) and the load/store port (D). Each access runs
// through IDLE (grant) -> BUSY (req/ack with the memory) -> RESP (one-cycle
// ready pulse to the owner). D normally has priority; a starvation counter
// forces a waiting fetch through after STARVE_MAX consecutive D grants, and a
// watchdog aborts an access that gets no ack within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    // Byte addresses are forced to word alignment before reaching memory.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_reg, state_next;
    logic          owner_d_reg, owner_d_next;     // 1 = D owns the access, 0 = I
    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
    logic [WW-1:0] wd_cnt_reg, wd_cnt_next;
    logic          err_reg, err_next;
    logic          mem_req_reg, mem_req_next;
    logic          mem_we_reg, mem_we_next;
    logic [31:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]   mem_wdata_reg, mem_wdata_next;
    logic          i_ready_reg, i_ready_next;
    logic [31:0]   i_rdata_reg, i_rdata_next;
    logic          d_ready_reg, d_ready_next;
    logic [31:0]   d_rdata_reg, d_rdata_next;

    logic d_any;
    logic force_i;

    assign d_any   = d_rd | d_wr;
    assign force_i = i_req && (starve_cnt_reg == SW'(STARVE_MAX));

    // State and output registers; reset also kills any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_d_reg    <= 1'b0;
            starve_cnt_reg <= '0;
            wd_cnt_reg     <= '0;
            err_reg        <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            i_ready_reg    <= 1'b0;
            i_rdata_reg    <= '0;
            d_ready_reg    <= 1'b0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_d_reg    <= owner_d_next;
            starve_cnt_reg <= starve_cnt_next;
            wd_cnt_reg     <= wd_cnt_next;
            err_reg        <= err_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            i_ready_reg    <= i_ready_next;
            i_rdata_reg    <= i_rdata_next;
            d_ready_reg    <= d_ready_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    // Grant, handshake and response sequencing.
    always_comb begin
        state_next      = state_reg;
        owner_d_next    = owner_d_reg;
        starve_cnt_next = starve_cnt_reg;
        wd_cnt_next     = wd_cnt_reg;
        err_next        = err_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        // Ready pulses and their data last a single cycle unless set below.
        i_ready_next    = 1'b0;
        i_rdata_next    = '0;
        d_ready_next    = 1'b0;
        d_rdata_next    = '0;

        case (state_reg)
            IDLE: begin
                wd_cnt_next = '0;
                if (d_rd && d_wr) begin
                    err_next = 1'b1;
                end
                if (d_any && !force_i) begin
                    owner_d_next    = 1'b1;
                    mem_addr_next   = d_addr & WORD_MASK;
                    mem_wdata_next  = d_wdata;
                    mem_we_next     = d_wr;          // rd+wr together is a store
                    mem_req_next    = 1'b1;
                    state_next      = BUSY;
                    // force_i is low here, so with i_req=1 the count is below
                    // STARVE_MAX and the increment saturates at STARVE_MAX.
                    starve_cnt_next = i_req ? (starve_cnt_reg + SW'(1)) : '0;
                end else if (i_req) begin
                    owner_d_next    = 1'b0;
                    mem_addr_next   = i_addr & WORD_MASK;
                    mem_wdata_next  = '0;
                    mem_we_next     = 1'b0;
                    mem_req_next    = 1'b1;
                    state_next      = BUSY;
                    starve_cnt_next = '0;
                end else begin
                    starve_cnt_next = '0;
                end
            end
            BUSY: begin
                wd_cnt_next = wd_cnt_reg + WW'(1);
                if (mem_ack || (wd_cnt_reg == WW'(TIMEOUT - 1))) begin
                    // An ack in the last allowed cycle still wins over abort.
                    mem_req_next = 1'b0;
                    state_next   = RESP;
                    if (!mem_ack) begin
                        err_next = 1'b1;
                    end
                    if (owner_d_reg) begin
                        d_ready_next = 1'b1;
                        d_rdata_next = mem_ack ? mem_rdata : 32'h0;
                    end else begin
                        i_ready_next = 1'b1;
                        i_rdata_next = mem_ack ? mem_rdata : 32'h0;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign i_ready   = i_ready_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_ready   = d_ready_reg;
    assign d_rdata   = d_rdata_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural memory answers
// mem_req after a programmable number of BUSY cycles and logs each grant;
// expected read data is pushed to per-port queues when a request is driven
// and popped when the matching ready pulse appears. Cycle numbers in the
// tests count the cycle in which a request is first driven as cycle 1.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    grant_t      grants[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    int ack_delay = 0;
    bit ack_en    = 1'b1;
    bit force_ack = 1'b0;
    int busy_cnt  = 0;

    mem_port_arbiter #(.STARVE_MAX(3), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model: acks in BUSY cycle index ack_delay and logs every grant.
    always @(negedge clk) begin
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
            busy_cnt  = 0;
        end else if (mem_req) begin
            if (busy_cnt == 0) grants.push_back({mem_we, mem_addr, mem_wdata});
            if (ack_en && busy_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_model(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
            busy_cnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            busy_cnt  = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1; i_req = 1'b1; d_rd = 1'b1; d_wr = 1'b1;
        i_addr = '1; d_addr = '1; d_wdata = '1; force_ack = 1'b1;
        tick(); tick();
        checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (i_ready !== 1'b0)  begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
        checks++; if (d_ready !== 1'b0)  begin errors++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
        checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        $display("txn reset: all inputs high during reset, outputs inspected");
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
        force_ack = 1'b0; reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_fetch();
        bit seen = 1'b0;
        logic [31:0] want;
        ack_en = 1'b1; ack_delay = 0;
        i_addr = 32'h0000_0046; i_req = 1'b1;
        exp_i.push_back(32'hDEAD_BEEF);
        for (int c = 2; c <= 12 && !seen; c++) begin
            tick();
            if (c == 2) begin
                checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
                checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL fetch_mem_addr: got %h want 00000044", mem_addr); end
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %b want 0", mem_we); end
            end
            if (i_ready) begin
                seen = 1'b1;
                want = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hxxxx_xxxx;
                checks++; if (c != 3) begin errors++; $display("FAIL fetch_latency: got cycle %0d want 3", c); end
                checks++; if (i_rdata !== want) begin errors++; $display("FAIL fetch_i_rdata: got %h want %h", i_rdata, want); end
                checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL fetch_d_rdata: got %h want 0", d_rdata); end
                i_req = 1'b0;
                $display("txn fetch: addr=%h rdata=%h cycle=%0d", i_addr, i_rdata, c);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL fetch_timeout: got no i_ready want one"); end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int d_cyc = 0;
        int i_cyc = 0;
        logic [31:0] want;
        ack_en = 1'b1; ack_delay = 2; grants.delete();
        i_addr = 32'h0000_010C; d_addr = 32'h80; d_wdata = 32'h1234;
        i_req = 1'b1; d_wr = 1'b1;
        exp_d.push_back(rd_model(32'h80));
        exp_i.push_back(rd_model(32'h10C));
        for (int c = 2; c <= 30 && (d_cyc == 0 || i_cyc == 0); c++) begin
            tick();
            if (d_ready) begin
                d_cyc = c;
                want = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxx_xxxx;
                checks++; if (d_rdata !== want) begin errors++; $display("FAIL cont_d_rdata: got %h want %h", d_rdata, want); end
                checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL cont_i_rdata_idle: got %h want 0", i_rdata); end
                d_wr = 1'b0;
                $display("txn contention store: addr=%h cycle=%0d", d_addr, c);
            end
            if (i_ready) begin
                i_cyc = c;
                want = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hxxxx_xxxx;
                checks++; if (i_rdata !== want) begin errors++; $display("FAIL cont_i_rdata: got %h want %h", i_rdata, want); end
                i_req = 1'b0;
                $display("txn contention fetch: addr=%h rdata=%h cycle=%0d", i_addr, i_rdata, c);
            end
        end
        checks++; if (d_cyc != 5) begin errors++; $display("FAIL cont_d_cycle: got %0d want 5", d_cyc); end
        checks++; if (i_cyc != 10) begin errors++; $display("FAIL cont_i_cycle: got %0d want 10", i_cyc); end
        checks++; if (grants.size() != 2) begin errors++; $display("FAIL cont_grants: got %0d want 2", grants.size()); end
        if (grants.size() == 2) begin
            checks++; if (grants[0] !== {1'b1, 32'h80, 32'h1234}) begin errors++; $display("FAIL cont_first_grant: got we=%b addr=%h wdata=%h want we=1 addr=00000080 wdata=00001234", grants[0].we, grants[0].addr, grants[0].wdata); end
            checks++; if (grants[1].we !== 1'b0 || grants[1].addr !== 32'h10C) begin errors++; $display("FAIL cont_second_grant: got we=%b addr=%h want we=0 addr=0000010c", grants[1].we, grants[1].addr); end
        end
        i_req = 1'b0; d_wr = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int  dn = 0;
        bit  seen = 1'b0;
        logic [31:0] want;
        logic [31:0] order [4];
        order[0] = 32'h100; order[1] = 32'h100; order[2] = 32'h100; order[3] = 32'h200;
        ack_en = 1'b1; ack_delay = 0; grants.delete();
        i_addr = 32'h200; d_addr = 32'h100; i_req = 1'b1; d_rd = 1'b1;
        for (int k = 0; k < 3; k++) exp_d.push_back(rd_model(32'h100));
        exp_i.push_back(rd_model(32'h200));
        for (int c = 2; c <= 40 && !seen; c++) begin
            tick();
            if (d_ready) begin
                dn++;
                want = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxx_xxxx;
                checks++; if (d_rdata !== want) begin errors++; $display("FAIL starve_d_rdata: got %h want %h", d_rdata, want); end
                $display("txn starvation load %0d: addr=%h cycle=%0d", dn, d_addr, c);
            end
            if (i_ready) begin
                seen = 1'b1;
                want = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hxxxx_xxxx;
                checks++; if (i_rdata !== want) begin errors++; $display("FAIL starve_i_rdata: got %h want %h", i_rdata, want); end
                checks++; if (dn != 3) begin errors++; $display("FAIL starve_d_before_i: got %0d want 3", dn); end
                checks++; if (dut.starve_cnt_reg !== 2'd0) begin errors++; $display("FAIL starve_cnt_after_i: got %0d want 0", dut.starve_cnt_reg); end
                i_req = 1'b0; d_rd = 1'b0;
                $display("txn starvation fetch: addr=%h cycle=%0d", i_addr, c);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL starve_timeout: got no i_ready want one"); end
        checks++; if (grants.size() != 4) begin errors++; $display("FAIL starve_grants: got %0d want 4", grants.size()); end
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            checks++; if (grants[k].addr !== order[k]) begin errors++; $display("FAIL starve_order_%0d: got %h want %h", k, grants[k].addr, order[k]); end
        end
        i_req = 1'b0; d_rd = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int  req_cyc = 0;
        bit  seen = 1'b0;
        logic [31:0] want;
        ack_en = 1'b0;
        d_addr = 32'h300; d_rd = 1'b1;
        exp_d.push_back(32'h0);
        for (int c = 2; c <= 200 && !seen; c++) begin
            tick();
            if (mem_req) req_cyc++;
            if (d_ready) begin
                seen = 1'b1;
                want = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxx_xxxx;
                checks++; if (d_rdata !== want) begin errors++; $display("FAIL timeout_d_rdata: got %h want %h", d_rdata, want); end
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
                d_rd = 1'b0;
                $display("txn timeout load: addr=%h req_cycles=%0d cycle=%0d", d_addr, req_cyc, c);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL timeout_no_ready: got no d_ready want one"); end
        checks++; if (req_cyc != 64) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 64", req_cyc); end
        d_rd = 1'b0; ack_en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_busy();
        int bc = 0;
        int pulses = 0;
        int reqs = 0;
        ack_en = 1'b1; ack_delay = 10;
        i_addr = 32'h400; i_req = 1'b1;
        for (int c = 2; c <= 20 && bc < 5; c++) begin
            tick();
            if (mem_req) bc++;
        end
        checks++; if (bc != 5) begin errors++; $display("FAIL rstbusy_reach: got %0d busy cycles want 5", bc); end
        reset = 1'b1; i_req = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstbusy_mem_req: got %b want 0", mem_req); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstbusy_err_cleared: got %b want 0", err); end
        reset = 1'b0; force_ack = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (i_ready || d_ready) pulses++;
            if (mem_req) reqs++;
        end
        force_ack = 1'b0;
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstbusy_pulses: got %0d want 0", pulses); end
        checks++; if (reqs != 0) begin errors++; $display("FAIL rstbusy_late_ack: got %0d req cycles want 0", reqs); end
        $display("txn reset mid-busy: addr=%h aborted after %0d busy cycles", i_addr, bc);
        tick();
    endtask

    task automatic test_rw_conflict();
        bit seen = 1'b0;
        logic [31:0] want;
        ack_en = 1'b1; ack_delay = 1; grants.delete();
        d_addr = 32'h502; d_wdata = 32'hCAFE; d_rd = 1'b1; d_wr = 1'b1;
        exp_d.push_back(rd_model(32'h500));
        for (int c = 2; c <= 20 && !seen; c++) begin
            tick();
            if (d_ready) begin
                seen = 1'b1;
                want = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxx_xxxx;
                checks++; if (c != 4) begin errors++; $display("FAIL rw_latency: got cycle %0d want 4", c); end
                checks++; if (d_rdata !== want) begin errors++; $display("FAIL rw_d_rdata: got %h want %h", d_rdata, want); end
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL rw_err: got %b want 1", err); end
                d_rd = 1'b0; d_wr = 1'b0;
                $display("txn rd+wr conflict: addr=%h cycle=%0d err=%b", d_addr, c, err);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rw_no_ready: got no d_ready want one"); end
        checks++; if (grants.size() != 1) begin errors++; $display("FAIL rw_grants: got %0d want 1", grants.size()); end
        if (grants.size() >= 1) begin
            checks++; if (grants[0] !== {1'b1, 32'h500, 32'hCAFE}) begin errors++; $display("FAIL rw_grant: got we=%b addr=%h wdata=%h want we=1 addr=00000500 wdata=0000cafe", grants[0].we, grants[0].addr, grants[0].wdata); end
        end
        d_rd = 1'b0; d_wr = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_fetch();
        test_contention();
        test_starvation();
        test_timeout();
        test_reset_mid_busy();
        test_rw_conflict();
        checks++; if (exp_i.size() != 0 || exp_d.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got i=%0d d=%0d want 0 0", exp_i.size(), exp_d.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
